// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiplier and restoring divider beside the EX-stage ALU.
// Latency: start cycle + XLEN BUSY cycles + 1 DONE cycle (XLEN+2); with MULDIV_FASTPATH_EN, divide-by-zero and DIV/REM overflow finish in 2.
// Backpressure: stall_EX freezes IF/ID/EX from the start cycle until DONE; flush aborts the op and drops stall_EX in the same cycle.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      FUNCT3_EX,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall_EX,
    output logic            done,
    output logic [XLEN-1:0] MULDIV_OUT_EX
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // latched operation context
    logic [2:0]      f3_q;
    logic            neg_q;     // product sign (mul) or quotient sign (div)
    logic            rneg_q;    // remainder sign
    logic [XLEN-1:0] hi_q;      // product high half / partial remainder
    logic [XLEN-1:0] lo_q;      // multiplier then product low half / dividend then quotient
    logic [XLEN-1:0] mcand_q;   // multiplicand magnitude / divisor magnitude
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] out_q;     // last delivered result, held while idle

    // operand decode
    logic            a_signed;
    logic            b_signed;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;
    logic            launch;
    logic            fast_c;

    // iteration datapath
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_t;
    logic [XLEN-1:0] div_diff;
    logic            div_ok;

    // result formation
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   result_c;

    // Which operands are interpreted as two's complement for each funct3
    always_comb begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        case (FUNCT3_EX)
            3'd2:    b_signed = 1'b0;                        // MULHSU
            3'd3,
            3'd5,
            3'd7:    begin a_signed = 1'b0; b_signed = 1'b0; end
            default: begin a_signed = 1'b1; b_signed = 1'b1; end
        endcase
    end

    assign neg_a  = a_signed & op_a[XLEN-1];
    assign neg_b  = b_signed & op_b[XLEN-1];
    assign a_mag  = neg_a ? (~op_a + 1'b1) : op_a;
    assign b_mag  = neg_b ? (~op_b + 1'b1) : op_b;
    assign b_zero = (op_b == '0);
    assign launch = (state == S_IDLE) & start & ~flush;

`ifdef MULDIV_FASTPATH_EN
    // Divides whose answer is fixed by the architecture skip the iterations entirely
    assign fast_c = FUNCT3_EX[2] &
                    (b_zero | (~FUNCT3_EX[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b)));
`else
    assign fast_c = 1'b0;
`endif

    // One shift-add step and one restoring-divide step, selected by the latched op
    always_comb begin
        mul_sum  = {1'b0, hi_q} + ({1'b0, mcand_q} & {(XLEN+1){lo_q[0]}});
        div_t    = {hi_q, lo_q[XLEN-1]};
        div_ok   = (div_t >= {1'b0, mcand_q});
        div_diff = div_t[XLEN-1:0] - mcand_q;
    end

    // Apply signs to the magnitudes and pick the architectural result
    always_comb begin
        prod     = {hi_q, lo_q};
        prod_s   = neg_q  ? (~prod + 1'b1) : prod;
        quo_s    = neg_q  ? (~lo_q + 1'b1) : lo_q;
        rem_s    = rneg_q ? (~hi_q + 1'b1) : hi_q;
        result_c = '0;
        case (f3_q)
            3'd0:       result_c = prod_s[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       result_c = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5: result_c = quo_s;
            default:    result_c = rem_s;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: flush always wins; DONE lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (launch) state_nxt = fast_c ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (flush)                              state_nxt = S_IDLE;
                else if (cnt_q == CNT_W'(XLEN - 1))     state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs: the start cycle is already stalled; reset forces everything quiet
    always_comb begin
        stall_EX      = 1'b0;
        done          = 1'b0;
        MULDIV_OUT_EX = out_q;
        case (state)
            S_IDLE: stall_EX = start & ~flush;
            S_BUSY: stall_EX = ~flush;
            S_DONE: begin
                done          = ~flush;
                MULDIV_OUT_EX = result_c;
            end
            default: stall_EX = 1'b0;
        endcase
        if (reset) begin
            stall_EX = 1'b0;
            done     = 1'b0;
        end
    end

    // Operand capture on launch, then one iteration per BUSY cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else if (launch) begin
            f3_q   <= FUNCT3_EX;
            // a zero divisor leaves the all-ones quotient un-negated
            neg_q  <= (neg_a ^ neg_b) & ~(FUNCT3_EX[2] & b_zero);
            rneg_q <= neg_a;
            cnt_q  <= '0;
            if (fast_c) begin
                hi_q    <= b_zero ? a_mag : '0;
                lo_q    <= b_zero ? '1 : a_mag;
                mcand_q <= b_mag;
            end else if (FUNCT3_EX[2]) begin
                hi_q    <= '0;
                lo_q    <= a_mag;
                mcand_q <= b_mag;
            end else begin
                hi_q    <= '0;
                lo_q    <= b_mag;
                mcand_q <= a_mag;
            end
        end else if (state == S_BUSY) begin
            cnt_q <= cnt_q + 1'b1;
            if (f3_q[2]) begin
                hi_q <= div_ok ? div_diff : div_t[XLEN-1:0];
                lo_q <= {lo_q[XLEN-2:0], div_ok};
            end else begin
                {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
            end
        end
    end

    // Keep the delivered result visible after DONE; a flushed result is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          out_q <= '0;
        else if (state == S_DONE && !flush) out_q <= result_c;
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model plus per-cycle compare, driven by directed M-op vectors.
// Expected results and latencies are literals; the model independently predicts stall/done/result every cycle.
// Every wait on the DUT is bounded so the run always reaches its summary line.
module tb_muldiv_seq;
    localparam int XLEN = 32;
    localparam int LAT_FULL = XLEN + 2;
`ifdef MULDIV_FASTPATH_EN
    localparam int LAT_SPECIAL = 2;
`else
    localparam int LAT_SPECIAL = XLEN + 2;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            flush;
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            stall_EX;
    logic            done;
    logic [XLEN-1:0] res;

    muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .flush         (flush),
        .FUNCT3_EX     (f3),
        .op_a          (a),
        .op_b          (b),
        .stall_EX      (stall_EX),
        .done          (done),
        .MULDIV_OUT_EX (res)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model state: cycles until the done cycle (0 = idle), pending and last delivered result
    int          m_cnt  = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_last = '0;

    logic        s_stall;
    logic        s_done;
    logic [31:0] s_out;

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, sp;
        logic [63:0] ux, uy, up;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        sp = '0;
        up = '0;
        case (f)
            3'd0: begin sp = sx * sy; return sp[31:0]; end
            3'd1: begin sp = sx * sy; return sp[63:32]; end
            3'd2: begin sp = sx * $signed(uy); return sp[63:32]; end
            3'd3: begin up = ux * uy; return up[63:32]; end
            3'd4: begin if (y == 0) return 32'hFFFFFFFF; sp = sx / sy; return sp[31:0]; end
            3'd5: begin if (y == 0) return 32'hFFFFFFFF; up = ux / uy; return up[31:0]; end
            3'd6: begin if (y == 0) return x; sp = sx % sy; return sp[31:0]; end
            default: begin if (y == 0) return x; up = ux % uy; return up[31:0]; end
        endcase
    endfunction

    function automatic bit ref_fast(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_FASTPATH_EN
        return f[2] && (y == 0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare DUT to the model mid-cycle, advance the model, return just after the edge
    task automatic tick();
        @(negedge clk);
        s_stall = stall_EX;
        s_done  = done;
        s_out   = res;
        if (reset) begin
            chk("rst_stall", {31'b0, s_stall}, 32'd0);
            chk("rst_done",  {31'b0, s_done},  32'd0);
            chk("rst_out",   s_out, 32'd0);
            m_cnt  = 0;
            m_last = '0;
        end else if (m_cnt == 0) begin
            chk("idle_stall", {31'b0, s_stall}, {31'b0, start & ~flush});
            chk("idle_done",  {31'b0, s_done},  32'd0);
            chk("idle_out",   s_out, m_last);
            if (start && !flush) begin
                m_res = ref_op(f3, a, b);
                m_cnt = ref_fast(f3, a, b) ? 1 : XLEN + 1;
            end
        end else if (m_cnt == 1) begin
            chk("done_stall", {31'b0, s_stall}, 32'd0);
            chk("done_done",  {31'b0, s_done},  {31'b0, ~flush});
            if (!flush) begin
                chk("done_out", s_out, m_res);
                m_last = m_res;
            end
            m_cnt = 0;
        end else begin
            chk("busy_stall", {31'b0, s_stall}, {31'b0, ~flush});
            chk("busy_done",  {31'b0, s_done},  32'd0);
            chk("busy_out",   s_out, m_last);
            m_cnt = flush ? 0 : m_cnt - 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, hold start while stalled, check result, latency and stall count
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp, input int exp_lat, output int done_cyc);
        int lat;
        int stalls;
        bit got;
        f3 = f; a = x; b = y; start = 1'b1; flush = 1'b0;
        lat = 0; stalls = 0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            lat++;
            if (s_stall) stalls++;
            if (s_done) got = 1;
        end
        start = 1'b0;
        done_cyc = cyc;
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no done within 100 cycles", name);
        end else begin
            chk(name, s_out, exp);
            chk({name, "_lat"}, lat, exp_lat);
            chk({name, "_stalls"}, stalls, exp_lat - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d1, d2, dn, seen;
        reset = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0;
        #3;
        chk("reset_stall", {31'b0, stall_EX}, 32'd0);
        chk("reset_done",  {31'b0, done},     32'd0);
        chk("reset_out",   res, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();

        run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT_FULL, dn);
        tick();
        chk("after_done_stall", {31'b0, s_stall}, 32'd0);
        chk("after_done_done",  {31'b0, s_done},  32'd0);

        run_op("mulhu_ff",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_FULL, dn);
        run_op("mulh_ff",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_FULL, dn);
        run_op("mulhsu_m1", 3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT_FULL, dn);
        run_op("div_m7_2",  3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT_FULL, dn);
        run_op("rem_m7_2",  3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT_FULL, dn);
        run_op("divu_100_7",3'd5, 32'd100,      32'd7,        32'd14,       LAT_FULL, dn);
        run_op("remu_100_7",3'd7, 32'd100,      32'd7,        32'd2,        LAT_FULL, dn);
        run_op("div_min_3", 3'd4, 32'h80000000, 32'd3,        32'hD5555556, LAT_FULL, dn);
        run_op("rem_min_3", 3'd6, 32'h80000000, 32'd3,        32'hFFFFFFFE, LAT_FULL, dn);

        run_op("div_5_0",   3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPECIAL, dn);
        run_op("rem_5_0",   3'd6, 32'd5,        32'd0,        32'd5,        LAT_SPECIAL, dn);
        run_op("divu_5_0",  3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPECIAL, dn);
        run_op("rem_m5_0",  3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT_SPECIAL, dn);
        run_op("div_ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPECIAL, dn);
        run_op("rem_ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SPECIAL, dn);
        tick();

        // flush while the iteration counter reads 10
        f3 = 3'd0; a = 32'd2; b = 32'd3; start = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        chk("flush_stall", {31'b0, s_stall}, 32'd0);
        chk("flush_done",  {31'b0, s_done},  32'd0);
        flush = 1'b0;
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_done) seen++;
        end
        chk("flush_no_done", seen, 32'd0);
        run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, LAT_FULL, dn);
        tick();

        // asynchronous reset in the middle of BUSY
        f3 = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        start = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_stall", {31'b0, stall_EX}, 32'd0);
        chk("arst_done",  {31'b0, done},     32'd0);
        chk("arst_out",   res, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // back-to-back: second op launched in the IDLE cycle right after DONE
        run_op("b2b_2x3", 3'd0, 32'd2, 32'd3, 32'd6,  LAT_FULL, d1);
        run_op("b2b_4x5", 3'd0, 32'd4, 32'd5, 32'd20, LAT_FULL, d2);
        chk("b2b_gap", d2 - d1, LAT_FULL);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
